// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: operand forwarding, load-use/RAW/WAW/structural hazard detection
// and a mul/div result scoreboard. Define HAZARD_PERF_EN to build the stall/flush counters.
module hazard_scoreboard #(
  parameter int REG_AW = 5,
  parameter int PERF_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [REG_AW-1:0]        IF_ID_Rs1,
  input  logic [REG_AW-1:0]        IF_ID_Rs2,
  input  logic [REG_AW-1:0]        IF_ID_Rd,
  input  logic                     IF_ID_RegWrite,
  input  logic                     IF_ID_MulDiv,
  input  logic [REG_AW-1:0]        ID_EX_Rs1,
  input  logic [REG_AW-1:0]        ID_EX_Rs2,
  input  logic [REG_AW-1:0]        ID_EX_Rd,
  input  logic                     ID_EX_MemRead,
  input  logic                     EX_MEM_RegWrite,
  input  logic [REG_AW-1:0]        EX_MEM_Rd,
  input  logic                     MEM_WB_RegWrite,
  input  logic [REG_AW-1:0]        MEM_WB_Rd,
  input  logic                     Branch_Taken,
  input  logic                     MD_Busy,
  input  logic                     MD_Done,
  input  logic [REG_AW-1:0]        MD_Rd,
  output logic [1:0]               ForwardA,
  output logic [1:0]               ForwardB,
  output logic                     Stall_IF_ID,
  output logic                     Flush_IF_ID,
  output logic                     Flush_ID_EX,
  output logic [(2**REG_AW)-1:0]   Pending,
  output logic [PERF_W-1:0]        Stall_Cnt,
  output logic [PERF_W-1:0]        Flush_Cnt
);

  localparam int NREG = 2**REG_AW;
  localparam logic [NREG-1:0] LP_BIT0 = NREG'(1);

  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_pend_eff;
  logic            w_load_use;
  logic            w_raw;
  logic            w_waw;
  logic            w_struct;
  logic            w_hazard;
  logic            w_issue;

  always_comb begin
    ForwardA = 2'b00;
    if (EX_MEM_RegWrite && (EX_MEM_Rd != '0) && (EX_MEM_Rd == ID_EX_Rs1))
      ForwardA = 2'b01;
    else if (MEM_WB_RegWrite && (MEM_WB_Rd != '0) && (MEM_WB_Rd == ID_EX_Rs1))
      ForwardA = 2'b10;
  end

  always_comb begin
    ForwardB = 2'b00;
    if (EX_MEM_RegWrite && (EX_MEM_Rd != '0) && (EX_MEM_Rd == ID_EX_Rs2))
      ForwardB = 2'b01;
    else if (MEM_WB_RegWrite && (MEM_WB_Rd != '0) && (MEM_WB_Rd == ID_EX_Rs2))
      ForwardB = 2'b10;
  end

  // A result retiring this cycle no longer blocks its consumers.
  assign w_clr      = MD_Done ? (LP_BIT0 << MD_Rd) : '0;
  assign w_pend_eff = r_pending & ~w_clr;

  assign w_load_use = ID_EX_MemRead && (ID_EX_Rd != '0) &&
                      ((ID_EX_Rd == IF_ID_Rs1) || (ID_EX_Rd == IF_ID_Rs2));
  assign w_raw      = w_pend_eff[IF_ID_Rs1] | w_pend_eff[IF_ID_Rs2];
  assign w_waw      = IF_ID_RegWrite & w_pend_eff[IF_ID_Rd];
  assign w_struct   = IF_ID_MulDiv & MD_Busy & ~MD_Done;
  assign w_hazard   = w_load_use | w_raw | w_waw | w_struct;

  assign Stall_IF_ID = w_hazard & ~Branch_Taken;
  assign Flush_IF_ID = Branch_Taken;
  assign Flush_ID_EX = Branch_Taken | w_hazard;

  assign w_issue = IF_ID_MulDiv & IF_ID_RegWrite & (IF_ID_Rd != '0) &
                   ~Stall_IF_ID & ~Branch_Taken;
  assign w_set   = w_issue ? (LP_BIT0 << IF_ID_Rd) : '0;

  // Set is applied after clear so a same-cycle issue to a retiring index wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_pending <= '0;
    else
      r_pending <= ((r_pending & ~w_clr) | w_set) & ~LP_BIT0;
  end

  assign Pending = r_pending;

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] r_stall_cnt;
  logic [PERF_W-1:0] r_flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (Stall_IF_ID && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + PERF_W'(1);
      if (Branch_Taken && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + PERF_W'(1);
    end
  end

  assign Stall_Cnt = r_stall_cnt;
  assign Flush_Cnt = r_flush_cnt;
`else
  assign Stall_Cnt = '0;
  assign Flush_Cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed table, corner sequences and
// randomized traffic against a behavioural model of the hazard/scoreboard rules.
module tb_hazard_scoreboard;
  localparam int AW   = 5;
  localparam int NR   = 1 << AW;
  localparam int PW   = 4;
  localparam int MAXC = (1 << PW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [AW-1:0] IF_ID_Rs1, IF_ID_Rs2, IF_ID_Rd;
  logic          IF_ID_RegWrite, IF_ID_MulDiv;
  logic [AW-1:0] ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd;
  logic          ID_EX_MemRead;
  logic          EX_MEM_RegWrite, MEM_WB_RegWrite;
  logic [AW-1:0] EX_MEM_Rd, MEM_WB_Rd;
  logic          Branch_Taken, MD_Busy, MD_Done;
  logic [AW-1:0] MD_Rd;
  logic [1:0]    ForwardA, ForwardB;
  logic          Stall_IF_ID, Flush_IF_ID, Flush_ID_EX;
  logic [NR-1:0] Pending;
  logic [PW-1:0] Stall_Cnt, Flush_Cnt;

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_AW(AW), .PERF_W(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_Rs1(IF_ID_Rs1), .IF_ID_Rs2(IF_ID_Rs2), .IF_ID_Rd(IF_ID_Rd),
    .IF_ID_RegWrite(IF_ID_RegWrite), .IF_ID_MulDiv(IF_ID_MulDiv),
    .ID_EX_Rs1(ID_EX_Rs1), .ID_EX_Rs2(ID_EX_Rs2), .ID_EX_Rd(ID_EX_Rd),
    .ID_EX_MemRead(ID_EX_MemRead),
    .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_Rd(EX_MEM_Rd),
    .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_Rd(MEM_WB_Rd),
    .Branch_Taken(Branch_Taken), .MD_Busy(MD_Busy), .MD_Done(MD_Done), .MD_Rd(MD_Rd),
    .ForwardA(ForwardA), .ForwardB(ForwardB),
    .Stall_IF_ID(Stall_IF_ID), .Flush_IF_ID(Flush_IF_ID), .Flush_ID_EX(Flush_ID_EX),
    .Pending(Pending), .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
  );

  int errors = 0;
  int checks = 0;

  bit model_pend [NR];
  int m_stall_cnt;
  int m_flush_cnt;

  typedef struct {
    logic          ex_we;  logic [AW-1:0] ex_rd;
    logic          wb_we;  logic [AW-1:0] wb_rd;
    logic [AW-1:0] rs1;    logic [AW-1:0] rs2;
    logic          mrd;    logic [AW-1:0] idex_rd;
    logic [AW-1:0] if_rs1; logic [AW-1:0] if_rs2;
    logic          br;
    logic [1:0]    fa;     logic [1:0]    fb;
    logic          stall;  logic fl_ifid; logic fl_idex;
  } vec_t;

  vec_t vt [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] m_fwd(input logic [AW-1:0] rs);
    if (EX_MEM_RegWrite && EX_MEM_Rd != 0 && EX_MEM_Rd == rs) return 2'b01;
    if (MEM_WB_RegWrite && MEM_WB_Rd != 0 && MEM_WB_Rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  // Register still awaiting its result, ignoring one that retires this cycle.
  function automatic bit m_busy(input logic [AW-1:0] r);
    return (r != 0) && model_pend[r] && !(MD_Done && MD_Rd == r);
  endfunction

  function automatic bit m_hazard();
    bit lu;
    lu = ID_EX_MemRead && ID_EX_Rd != 0 && (ID_EX_Rd == IF_ID_Rs1 || ID_EX_Rd == IF_ID_Rs2);
    return lu || m_busy(IF_ID_Rs1) || m_busy(IF_ID_Rs2) ||
           (IF_ID_RegWrite && m_busy(IF_ID_Rd)) || (IF_ID_MulDiv && MD_Busy && !MD_Done);
  endfunction

  function automatic logic [NR-1:0] m_pend_vec();
    logic [NR-1:0] v;
    v = '0;
    for (int i = 1; i < NR; i++) v[i] = model_pend[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) model_pend[i] = 1'b0;
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    bit hz;
    hz = m_hazard();
    chk({tag, "_fwdA"}, 64'(ForwardA), 64'(m_fwd(ID_EX_Rs1)));
    chk({tag, "_fwdB"}, 64'(ForwardB), 64'(m_fwd(ID_EX_Rs2)));
    chk({tag, "_stall"}, 64'(Stall_IF_ID), 64'(hz && !Branch_Taken));
    chk({tag, "_flush_ifid"}, 64'(Flush_IF_ID), 64'(Branch_Taken));
    chk({tag, "_flush_idex"}, 64'(Flush_ID_EX), 64'(hz || Branch_Taken));
    chk({tag, "_pending"}, 64'(Pending), 64'(m_pend_vec()));
`ifdef HAZARD_PERF_EN
    chk({tag, "_stall_cnt"}, 64'(Stall_Cnt), 64'(m_stall_cnt));
    chk({tag, "_flush_cnt"}, 64'(Flush_Cnt), 64'(m_flush_cnt));
`else
    chk({tag, "_stall_cnt"}, 64'(Stall_Cnt), 64'(0));
    chk({tag, "_flush_cnt"}, 64'(Flush_Cnt), 64'(0));
`endif
  endtask

  // Clock edge with the current inputs held; model follows the same edge.
  task automatic advance();
    bit st, iss, done, br;
    logic [AW-1:0] rd, mdrd;
    st   = m_hazard() && !Branch_Taken;
    br   = Branch_Taken;
    iss  = IF_ID_MulDiv && IF_ID_RegWrite && IF_ID_Rd != 0 && !st && !br;
    rd   = IF_ID_Rd;
    done = MD_Done;
    mdrd = MD_Rd;
    @(posedge clk);
    if (st && m_stall_cnt < MAXC) m_stall_cnt++;
    if (br && m_flush_cnt < MAXC) m_flush_cnt++;
    if (done) model_pend[mdrd] = 1'b0;
    if (iss) model_pend[rd] = 1'b1;
    #1;
  endtask

  task automatic idle();
    {IF_ID_Rs1, IF_ID_Rs2, IF_ID_Rd, IF_ID_RegWrite, IF_ID_MulDiv} = '0;
    {ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd, ID_EX_MemRead} = '0;
    {EX_MEM_RegWrite, EX_MEM_Rd, MEM_WB_RegWrite, MEM_WB_Rd} = '0;
    {Branch_Taken, MD_Busy, MD_Done, MD_Rd} = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic issue_md(input logic [AW-1:0] rd);
    idle();
    IF_ID_MulDiv = 1'b1; IF_ID_RegWrite = 1'b1; IF_ID_Rd = rd;
  endtask

  initial begin
    vt[0] = '{1'b1, 5'd5, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 5'd0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
    vt[2] = '{1'b0, 5'd5, 1'b1, 5'd5, 5'd5, 5'd5, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0};
    vt[3] = '{1'b1, 5'd3, 1'b1, 5'd4, 5'd4, 5'd3, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0};
    vt[4] = '{1'b1, 5'd6, 1'b0, 5'd6, 5'd6, 5'd6, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0};
    vt[5] = '{1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1};
    vt[6] = '{1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    vt[7] = '{1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd7, 5'd7, 5'd2, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1};
    vt[8] = '{1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd7, 5'd7, 5'd7, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};

    model_reset();
    idle();
    #3;
    do_reset();

    for (int i = 0; i < 9; i++) begin
      idle();
      EX_MEM_RegWrite = vt[i].ex_we; EX_MEM_Rd = vt[i].ex_rd;
      MEM_WB_RegWrite = vt[i].wb_we; MEM_WB_Rd = vt[i].wb_rd;
      ID_EX_Rs1 = vt[i].rs1; ID_EX_Rs2 = vt[i].rs2;
      ID_EX_MemRead = vt[i].mrd; ID_EX_Rd = vt[i].idex_rd;
      IF_ID_Rs1 = vt[i].if_rs1; IF_ID_Rs2 = vt[i].if_rs2;
      Branch_Taken = vt[i].br;
      #2;
      chk($sformatf("vec%0d_fwdA", i), 64'(ForwardA), 64'(vt[i].fa));
      chk($sformatf("vec%0d_fwdB", i), 64'(ForwardB), 64'(vt[i].fb));
      chk($sformatf("vec%0d_stall", i), 64'(Stall_IF_ID), 64'(vt[i].stall));
      chk($sformatf("vec%0d_flush_ifid", i), 64'(Flush_IF_ID), 64'(vt[i].fl_ifid));
      chk($sformatf("vec%0d_flush_idex", i), 64'(Flush_ID_EX), 64'(vt[i].fl_idex));
      check_all($sformatf("vec%0d", i));
      advance();
    end

    // Mul to x9, dependent consumer stalls until the retiring cycle.
    issue_md(5'd9);
    #2; check_all("md9_issue");
    advance();
    chk("md9_pending_set", 64'(Pending[9]), 64'(1));
    idle();
    IF_ID_Rs1 = 5'd9; MD_Busy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      chk($sformatf("md9_wait%0d_stall", c), 64'(Stall_IF_ID), 64'(1));
      check_all("md9_wait");
      advance();
    end
    MD_Done = 1'b1; MD_Rd = 5'd9;
    #2;
    chk("md9_done_stall", 64'(Stall_IF_ID), 64'(0));
    check_all("md9_done");
    advance();
    chk("md9_pending_clear", 64'(Pending[9]), 64'(0));

    // Issue and retire the same index in one cycle: set wins.
    issue_md(5'd3);
    MD_Done = 1'b1; MD_Rd = 5'd3;
    #2; check_all("x3_setclr");
    advance();
    chk("x3_set_wins", 64'(Pending[3]), 64'(1));

    // WAW against x3, then branch during a load-use with a mul issue attempt.
    idle();
    IF_ID_RegWrite = 1'b1; IF_ID_Rd = 5'd3;
    #2;
    chk("waw_x3_stall", 64'(Stall_IF_ID), 64'(1));
    check_all("waw_x3");
    advance();
    issue_md(5'd11);
    ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd12; IF_ID_Rs1 = 5'd12;
    Branch_Taken = 1'b1;
    #2;
    chk("br_lu_stall", 64'(Stall_IF_ID), 64'(0));
    chk("br_lu_flush_ifid", 64'(Flush_IF_ID), 64'(1));
    chk("br_lu_flush_idex", 64'(Flush_ID_EX), 64'(1));
    check_all("br_lu");
    advance();
    chk("br_lu_no_pend_change", 64'(Pending), 64'(NR'(1) << 3));

    // Counters: 4 stalls, 2 flushes, then reset in the middle of a stall.
    do_reset();
    idle();
    ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd7; IF_ID_Rs2 = 5'd7;
    for (int c = 0; c < 4; c++) begin
      #2; check_all("cnt_stall"); advance();
    end
    idle();
    Branch_Taken = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #2; check_all("cnt_flush"); advance();
    end
    idle();
    #2;
`ifdef HAZARD_PERF_EN
    chk("cnt_stall_eq4", 64'(Stall_Cnt), 64'(4));
    chk("cnt_flush_eq2", 64'(Flush_Cnt), 64'(2));
`else
    chk("cnt_stall_off", 64'(Stall_Cnt), 64'(0));
    chk("cnt_flush_off", 64'(Flush_Cnt), 64'(0));
`endif
    issue_md(5'd5);
    #2; check_all("pre_rst_issue");
    advance();
    idle();
    ID_EX_MemRead = 1'b1; ID_EX_Rd = 5'd7; IF_ID_Rs1 = 5'd7;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_pending", 64'(Pending), 64'(0));
    chk("midrst_stall_cnt", 64'(Stall_Cnt), 64'(0));
    chk("midrst_flush_cnt", 64'(Flush_Cnt), 64'(0));
    model_reset();
    idle();
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    MD_Done = 1'b1; MD_Rd = 5'd5;
    #2; check_all("stale_done");
    advance();
    idle();
    IF_ID_Rs1 = 5'd5;
    #2; check_all("stale_after");
    advance();

    // Randomized traffic on a narrow register range so hazards actually occur.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      IF_ID_Rs1       = AW'($urandom_range(0, 7));
      IF_ID_Rs2       = AW'($urandom_range(0, 7));
      IF_ID_Rd        = AW'($urandom_range(0, 7));
      IF_ID_RegWrite  = 1'($urandom_range(0, 1));
      IF_ID_MulDiv    = ($urandom_range(0, 2) == 0);
      ID_EX_Rs1       = AW'($urandom_range(0, 7));
      ID_EX_Rs2       = AW'($urandom_range(0, 7));
      ID_EX_Rd        = AW'($urandom_range(0, 7));
      ID_EX_MemRead   = ($urandom_range(0, 3) == 0);
      EX_MEM_RegWrite = 1'($urandom_range(0, 1));
      EX_MEM_Rd       = AW'($urandom_range(0, 7));
      MEM_WB_RegWrite = 1'($urandom_range(0, 1));
      MEM_WB_Rd       = AW'($urandom_range(0, 7));
      Branch_Taken    = ($urandom_range(0, 7) == 0);
      MD_Busy         = 1'($urandom_range(0, 1));
      MD_Done         = ($urandom_range(0, 2) == 0);
      MD_Rd           = AW'($urandom_range(0, 7));
      #2;
      check_all($sformatf("rnd%0d", n));
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
